// File: rtl/spi_disp_pkg.sv
// Shared types and constants for the SPI display transmitter path.
package spi_disp_pkg;

  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } rgb565_t;

  typedef enum logic [1:0] {IDLE, LOW, HIGH, HOLD} spi_state_t;

  localparam logic DC_CMD   = 1'b0;
  localparam logic DC_DATA  = 1'b1;
  localparam int   CMD_BITS = 8;
  localparam int   PIX_BITS = 16;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with show-ahead output; extra pointer bit separates full from empty.
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             srst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  assign do_push  = push_i && !full_o;
  assign do_pop   = pop_i && !empty_o;
  assign wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
  assign rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din_i;
  end

  assign dout_o  = mem_q[rd_ptr_q[AW-1:0]];
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

endmodule

// File: rtl/spi_pixel_tx.sv
// SPI mode-0 display transmitter: 8-bit commands (DC=0) and RGB565 pixels (DC=1), MSB first.
// Define SPI_PIX_FIFO_EN to place a PIX_FIFO_DEPTH-entry pixel FIFO in front of the shifter.
module spi_pixel_tx
  import spi_disp_pkg::*;
#(
  parameter int CLK_DIV        = 2,
  parameter int PIX_FIFO_DEPTH = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        CMD_VALID,
  input  logic [7:0]  CMD_DATA,
  output logic        CMD_READY,
  input  logic        PIX_VALID,
  input  logic [15:0] PIX_DATA,
  output logic        PIX_READY,
  output logic        BUSY,
  output logic        SCLK,
  output logic        MOSI,
  output logic        CS_N,
  output logic        DC
);
  localparam int               DIV_W    = $clog2(CLK_DIV + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

  if (CLK_DIV < 1 || PIX_FIFO_DEPTH < 2 || (PIX_FIFO_DEPTH & (PIX_FIFO_DEPTH - 1)) != 0) begin : g_param_check
    $error("spi_pixel_tx: CLK_DIV must be >= 1 and PIX_FIFO_DEPTH a power of 2 >= 2");
  end

  spi_state_t       state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [3:0]       bit_q, bit_d;
  logic [15:0]      shreg_q, shreg_d;
  logic             is_pix_q, is_pix_d;
  logic             dc_q, dc_d;
  logic [3:0]       bit_last;
  logic             shifter_ready, cmd_take, pix_take;
  rgb565_t          pix_word;

  // The shifter can take a new item while idle or in the last HOLD cycle (seamless back-to-back).
  assign shifter_ready = (state_q == IDLE) || (state_q == HOLD && div_q == DIV_LAST);

`ifdef SPI_PIX_FIFO_EN
  logic        fifo_full, fifo_empty;
  logic [15:0] fifo_dout;

  sync_fifo #(
    .WIDTH (16),
    .DEPTH (PIX_FIFO_DEPTH)
  ) u_pix_fifo (
    .clk_i   (CLK),
    .srst_i  (RST),
    .push_i  (PIX_VALID && PIX_READY),
    .din_i   (PIX_DATA),
    .pop_i   (pix_take),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Commands wait for the FIFO to drain so they never overtake queued pixels.
  assign PIX_READY = !RST && !fifo_full;
  assign CMD_READY = !RST && shifter_ready && fifo_empty;
  assign cmd_take  = CMD_VALID && CMD_READY;
  assign pix_take  = !RST && shifter_ready && !fifo_empty;
  assign pix_word  = fifo_dout;
  assign BUSY      = (state_q != IDLE) || !fifo_empty;
`else
  assign CMD_READY = !RST && shifter_ready;
  assign PIX_READY = !RST && shifter_ready && !CMD_VALID;
  assign cmd_take  = CMD_VALID && CMD_READY;
  assign pix_take  = PIX_VALID && PIX_READY;
  assign pix_word  = PIX_DATA;
  assign BUSY      = (state_q != IDLE);
`endif

  assign bit_last = is_pix_q ? 4'(PIX_BITS - 1) : 4'(CMD_BITS - 1);

  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    bit_d    = bit_q;
    shreg_d  = shreg_q;
    is_pix_d = is_pix_q;
    dc_d     = dc_q;
    case (state_q)
      LOW: begin
        if (div_q == DIV_LAST) begin
          div_d   = '0;
          state_d = HIGH;
        end else begin
          div_d = div_q + DIV_ONE;
        end
      end
      HIGH: begin
        if (div_q == DIV_LAST) begin
          div_d = '0;
          if (bit_q == bit_last) begin
            state_d = HOLD;
          end else begin
            state_d = LOW;
            bit_d   = bit_q + 4'd1;
            shreg_d = {shreg_q[14:0], 1'b0};
          end
        end else begin
          div_d = div_q + DIV_ONE;
        end
      end
      HOLD: begin
        if (div_q == DIV_LAST) begin
          div_d   = '0;
          state_d = IDLE;
        end else begin
          div_d = div_q + DIV_ONE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A handshake only happens while shifter_ready, so it overrides the HOLD exit above.
    if (cmd_take) begin
      state_d  = LOW;
      div_d    = '0;
      bit_d    = '0;
      shreg_d  = {CMD_DATA, 8'h00};
      is_pix_d = 1'b0;
      dc_d     = DC_CMD;
    end else if (pix_take) begin
      state_d  = LOW;
      div_d    = '0;
      bit_d    = '0;
      shreg_d  = pix_word;
      is_pix_d = 1'b1;
      dc_d     = DC_DATA;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      div_q    <= '0;
      bit_q    <= '0;
      shreg_q  <= '0;
      is_pix_q <= 1'b0;
      dc_q     <= DC_CMD;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      bit_q    <= bit_d;
      shreg_q  <= shreg_d;
      is_pix_q <= is_pix_d;
      dc_q     <= dc_d;
    end
  end

  assign SCLK = (state_q == HIGH);
  assign MOSI = ((state_q == LOW) || (state_q == HIGH)) && shreg_q[15];
  assign CS_N = (state_q == IDLE);
  assign DC   = dc_q;

endmodule

// File: tb/tb_spi_pixel_tx.sv
// Bench for spi_pixel_tx: timing-level reference model checked every cycle, a table of single
// items, directed multi-cycle sequences, then random traffic with occasional resets.
module tb_spi_pixel_tx;
  localparam int D = 2;

  logic        CLK = 1'b0;
  logic        RST, CMD_VALID, PIX_VALID;
  logic [7:0]  CMD_DATA;
  logic [15:0] PIX_DATA;
  logic        CMD_READY, PIX_READY, BUSY, SCLK, MOSI, CS_N, DC;

  spi_pixel_tx #(
    .CLK_DIV        (D),
    .PIX_FIFO_DEPTH (4)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .CMD_VALID (CMD_VALID),
    .CMD_DATA  (CMD_DATA),
    .CMD_READY (CMD_READY),
    .PIX_VALID (PIX_VALID),
    .PIX_DATA  (PIX_DATA),
    .PIX_READY (PIX_READY),
    .BUSY      (BUSY),
    .SCLK      (SCLK),
    .MOSI      (MOSI),
    .CS_N      (CS_N),
    .DC        (DC)
  );

  always #5 CLK = ~CLK;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  // Reference model: the item in flight is described by its accept cycle, length and data;
  // every bus output is derived from the cycle offset into that item.
  bit          m_act = 1'b0;
  int          m_t = 0;
  int          m_n = 8;
  logic [15:0] m_data = '0;
  logic        m_dc = 1'b0;

  // Bus monitor state: SCLK rising edges as seen by the display.
  int           edges = 0, dc_hi = 0, low_cycles = 0, cs_rises = 0, edges_cs_high = 0, prdy_low = 0;
  logic [127:0] cap = '0;
  logic         prev_sclk = 1'b0, prev_csn = 1'b1;

  typedef struct {
    bit          is_cmd;
    logic [15:0] data;
    logic [15:0] exp_bits;
    int          exp_edges;
    int          exp_cycles;
    int          exp_dc_edges;
  } vec_t;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got 0x%0h, required 0x%0h", name, cyc, got, exp);
    end
  endtask

  task automatic tick(output bit ac, output bit ap);
    int dur, o;
    bit in_win, in_bits, rdy;
    logic [5:0] got6, exp6;
    @(negedge CLK);
    ac = 1'b0;
    ap = 1'b0;
`ifndef SPI_PIX_FIFO_EN
    dur     = m_n * 2 * D + D;
    in_win  = m_act && cyc > m_t && cyc <= m_t + dur;
    o       = cyc - m_t - 1;
    in_bits = in_win && o < m_n * 2 * D;
    rdy     = !RST && (!m_act || cyc >= m_t + dur);
    exp6    = {!in_win, in_bits && (o % (2 * D)) >= D, m_dc, in_win, rdy, rdy && !CMD_VALID};
    got6    = {CS_N, SCLK, DC, BUSY, CMD_READY, PIX_READY};
    check("csn_sclk_dc_busy_crdy_prdy", 128'(got6), 128'(exp6));
    if (in_bits) check("mosi", 128'(MOSI), 128'(m_data[m_n - 1 - o / (2 * D)]));
    if (RST) begin
      m_act = 1'b0;
      m_dc  = 1'b0;
    end else if (rdy && CMD_VALID) begin
      ac = 1'b1; m_act = 1'b1; m_t = cyc; m_n = 8; m_data = {8'h00, CMD_DATA}; m_dc = 1'b0;
    end else if (rdy && PIX_VALID) begin
      ap = 1'b1; m_act = 1'b1; m_t = cyc; m_n = 16; m_data = PIX_DATA; m_dc = 1'b1;
    end
`else
    ac = !RST && CMD_VALID && CMD_READY;
    ap = !RST && PIX_VALID && PIX_READY;
    if (!RST && !PIX_READY) prdy_low++;
`endif
    if (SCLK && !prev_sclk) begin
      edges++;
      cap = {cap[126:0], MOSI};
      if (DC) dc_hi++;
      if (CS_N) edges_cs_high++;
    end
    if (!CS_N) low_cycles++;
    if (CS_N && !prev_csn) cs_rises++;
    prev_sclk = SCLK;
    prev_csn  = CS_N;
    @(posedge CLK);
    cyc++;
    #1;
  endtask

  task automatic idle(input int n);
    bit ac, ap;
    for (int i = 0; i < n; i++) tick(ac, ap);
  endtask

  task automatic wait_acc(input bit want_cmd);
    bit ac, ap, hit;
    int n;
    n = 0;
    hit = 1'b0;
    while (!hit && n < 300) begin
      tick(ac, ap);
      hit = want_cmd ? ac : ap;
      n++;
    end
    check(want_cmd ? "cmd_handshake" : "pix_handshake", 128'(hit), 128'(1));
  endtask

  task automatic send(input bit is_cmd, input logic [15:0] data);
    if (is_cmd) begin
      CMD_VALID = 1'b1; CMD_DATA = data[7:0];
    end else begin
      PIX_VALID = 1'b1; PIX_DATA = data;
    end
    wait_acc(is_cmd);
    // Scramble the payload after the handshake: the shifter must have latched it.
    CMD_VALID = 1'b0; PIX_VALID = 1'b0;
    CMD_DATA = 8'($urandom); PIX_DATA = 16'($urandom);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ac, ap;
    int e0, l0, d0, r0, n;
    logic [15:0] mask;
    vec_t tbl[7];
    tbl[0] = '{1'b1, 16'h002C, 16'h002C, 8, 34, 0};
    tbl[1] = '{1'b0, 16'hF800, 16'hF800, 16, 66, 16};
    tbl[2] = '{1'b1, 16'h00FF, 16'h00FF, 8, 34, 0};
    tbl[3] = '{1'b0, 16'h0001, 16'h0001, 16, 66, 16};
    tbl[4] = '{1'b1, 16'h0081, 16'h0081, 8, 34, 0};
    tbl[5] = '{1'b0, 16'hA55A, 16'hA55A, 16, 66, 16};
    tbl[6] = '{1'b0, 16'h8000, 16'h8000, 16, 66, 16};

    RST = 1'b1; CMD_VALID = 1'b0; PIX_VALID = 1'b0; CMD_DATA = '0; PIX_DATA = '0;
    repeat (2) @(posedge CLK);
    #1;
    check("reset_outputs", 128'({CS_N, SCLK, MOSI, DC, BUSY, CMD_READY, PIX_READY}), 128'(7'b1000000));
    idle(2);
    RST = 1'b0;

`ifndef SPI_PIX_FIFO_EN
    for (int i = 0; i < 7; i++) begin
      e0 = edges; l0 = low_cycles; d0 = dc_hi;
      send(tbl[i].is_cmd, tbl[i].data);
      idle(tbl[i].exp_cycles + 3);
      mask = 16'((32'h1 << tbl[i].exp_edges) - 1);
      check("row_edges", 128'(edges - e0), 128'(tbl[i].exp_edges));
      check("row_bits", 128'(cap[15:0] & mask), 128'(tbl[i].exp_bits));
      check("row_cs_low_cycles", 128'(low_cycles - l0), 128'(tbl[i].exp_cycles));
      check("row_dc_at_edges", 128'(dc_hi - d0), 128'(tbl[i].exp_dc_edges));
      check("row_dc_hold", 128'(DC), 128'(!tbl[i].is_cmd));
      $display("row %0d: %s 0x%04h -> %0d edges, CS_N low %0d cycles", i,
               tbl[i].is_cmd ? "cmd" : "pix", tbl[i].data, edges - e0, low_cycles - l0);
    end

    // Two pixels with PIX_VALID held: seamless, one CS_N rise at the end.
    e0 = edges; r0 = cs_rises;
    PIX_VALID = 1'b1; PIX_DATA = 16'h001F;
    wait_acc(1'b0);
    PIX_DATA = 16'h07E0;
    wait_acc(1'b0);
    PIX_VALID = 1'b0; PIX_DATA = 16'($urandom);
    idle(70);
    check("b2b_edges", 128'(edges - e0), 128'(32));
    check("b2b_bits", 128'(cap[31:0]), 128'(32'h001F_07E0));
    check("b2b_cs_rises", 128'(cs_rises - r0), 128'(1));
    $display("pix pair 0x001F,0x07E0 -> %0d edges, %0d CS_N rises", edges - e0, cs_rises - r0);

    // Command and pixel offered together: command first, pixel follows without a CS_N gap.
    e0 = edges; r0 = cs_rises; d0 = dc_hi;
    CMD_VALID = 1'b1; CMD_DATA = 8'h2A; PIX_VALID = 1'b1; PIX_DATA = 16'hFFFF;
    #1;
    check("tie_cmd_ready", 128'(CMD_READY), 128'(1));
    check("tie_pix_ready", 128'(PIX_READY), 128'(0));
    wait_acc(1'b1);
    CMD_VALID = 1'b0; CMD_DATA = 8'($urandom);
    wait_acc(1'b0);
    PIX_VALID = 1'b0; PIX_DATA = 16'($urandom);
    idle(70);
    check("tie_edges", 128'(edges - e0), 128'(24));
    check("tie_bits", 128'(cap[23:0]), 128'(24'h2A_FFFF));
    check("tie_cs_rises", 128'(cs_rises - r0), 128'(1));
    check("tie_dc_edges", 128'(dc_hi - d0), 128'(16));
    $display("cmd 0x2A + pix 0xFFFF -> %0d edges, %0d with DC=1", edges - e0, dc_hi - d0);

    // Reset after the 5th rising edge of a pixel, then a clean pixel.
    e0 = edges;
    send(1'b0, 16'hABCD);
    n = 0;
    while (edges - e0 < 5 && n < 200) begin
      tick(ac, ap);
      n++;
    end
    check("rst_reach_5_edges", 128'(edges - e0), 128'(5));
    RST = 1'b1;
    tick(ac, ap);
    RST = 1'b0;
    #1;
    check("rst_outputs_next_cycle", 128'({CS_N, SCLK, MOSI, DC, BUSY}), 128'(5'b10000));
    check("rst_cmd_ready_after", 128'(CMD_READY), 128'(1));
    idle(40);
    check("rst_no_more_edges", 128'(edges - e0), 128'(5));
    e0 = edges;
    send(1'b0, 16'h1234);
    idle(70);
    check("rst_next_pix_edges", 128'(edges - e0), 128'(16));
    check("rst_next_pix_bits", 128'(cap[15:0]), 128'(16'h1234));
    $display("pix 0xABCD aborted after 5 edges; pix 0x1234 -> %0d edges", edges - e0);

    for (int i = 0; i < 4000; i++) begin
      RST = ($urandom_range(0, 249) == 0);
      if (!CMD_VALID && $urandom_range(0, 24) == 0) begin
        CMD_VALID = 1'b1; CMD_DATA = 8'($urandom);
      end
      if (!PIX_VALID && $urandom_range(0, 5) == 0) begin
        PIX_VALID = 1'b1; PIX_DATA = 16'($urandom);
      end
      tick(ac, ap);
      if (ac) begin
        CMD_DATA = 8'($urandom); CMD_VALID = ($urandom_range(0, 3) == 0);
      end
      if (ap) begin
        PIX_DATA = 16'($urandom); PIX_VALID = ($urandom_range(0, 1) == 0);
      end
    end
    RST = 1'b0; CMD_VALID = 1'b0; PIX_VALID = 1'b0;
    idle(80);
    $display("random traffic: %0d cycles done", cyc);
`else
    // Five pixels streamed into the FIFO; a command offered meanwhile must wait for the drain.
    begin
      int k, cmd_edges;
      bit done;
      e0 = edges; r0 = cs_rises;
      k = 1; cmd_edges = -1; done = 1'b0; n = 0;
      PIX_VALID = 1'b1; PIX_DATA = 16'h0001;
      while (!done && n < 600) begin
        tick(ac, ap);
        n++;
        if (ap) begin
          if (k == 3) begin
            CMD_VALID = 1'b1; CMD_DATA = 8'h99;
          end
          if (k == 5) PIX_VALID = 1'b0;
          else begin
            k++; PIX_DATA = 16'(k);
          end
        end
        if (ac) begin
          CMD_VALID = 1'b0; cmd_edges = edges - e0; done = 1'b1;
        end
      end
      idle(50);
      check("fifo_cmd_waited", 128'(cmd_edges), 128'(80));
      check("fifo_edges", 128'(edges - e0), 128'(88));
      check("fifo_bits", 128'(cap[87:0]),
            128'({16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005, 8'h99}));
      check("fifo_cs_rises", 128'(cs_rises - r0), 128'(1));
      check("fifo_pix_ready_dropped", 128'(prdy_low > 0), 128'(1));
      $display("fifo stream 0x0001..0x0005 + cmd 0x99 -> %0d edges, cmd after %0d", edges - e0, cmd_edges);
    end
`endif

    check("sclk_edges_while_cs_high", 128'(edges_cs_high), 128'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
